// File: rtl/exibe_sequencia.sv
// Plays stored jogadas 0..rodada on leds: each lit TEMPO_ACESO cycles, then dark TEMPO_APAGADO.
// Optional feature macro: EXIBE_PISCA_FIM_EN (all-on flash before FIM).
module exibe_sequencia #(
  parameter int unsigned TEMPO_ACESO   = 500,
  parameter int unsigned TEMPO_APAGADO = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic [3:0] rodada,
  input  logic [3:0] mem_dado,
  output logic [3:0] mem_endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int unsigned TMAX = (TEMPO_ACESO > TEMPO_APAGADO) ? TEMPO_ACESO : TEMPO_APAGADO;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] FIM_ACESO   = TW'(TEMPO_ACESO - 1);
  localparam logic [TW-1:0] FIM_APAGADO = TW'(TEMPO_APAGADO - 1);
`ifdef EXIBE_PISCA_FIM_EN
  localparam logic [TW-1:0] FIM_PISCA   = TW'(TEMPO_ACESO);
`endif

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    CARREGA = 4'd1,
    ACESO   = 4'd2,
    APAGADO = 4'd3,
    FIM     = 4'd4
`ifdef EXIBE_PISCA_FIM_EN
    ,
    PISCA   = 4'd5
`endif
  } estado_t;

  estado_t       state_q, state_d;
  logic [3:0]    leds_q, leds_d;
  logic [3:0]    end_q, end_d;
  logic [3:0]    rodada_q, rodada_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pronto_q, pronto_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= INICIAL;
      leds_q   <= '0;
      end_q    <= '0;
      rodada_q <= '0;
      timer_q  <= '0;
      pronto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      leds_q   <= leds_d;
      end_q    <= end_d;
      rodada_q <= rodada_d;
      timer_q  <= timer_d;
      pronto_q <= pronto_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    leds_d   = leds_q;
    end_d    = end_q;
    rodada_d = rodada_q;
    timer_d  = timer_q;
    pronto_d = 1'b0;

    case (state_q)
      INICIAL: begin
        leds_d = '0;
        if (iniciar && !parar) begin
          rodada_d = rodada;
          end_d    = '0;
          timer_d  = '0;
          state_d  = CARREGA;
        end
      end
      CARREGA: begin
        leds_d  = mem_dado;
        timer_d = '0;
        state_d = ACESO;
      end
      ACESO: begin
        if (timer_q == FIM_ACESO) begin
          leds_d  = '0;
          timer_d = '0;
          state_d = APAGADO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      APAGADO: begin
        if (timer_q == FIM_APAGADO) begin
          timer_d = '0;
          if (end_q == rodada_q) begin
`ifdef EXIBE_PISCA_FIM_EN
            state_d  = PISCA;
`else
            state_d  = FIM;
            pronto_d = 1'b1;
`endif
          end else begin
            end_d   = end_q + 4'd1;
            state_d = CARREGA;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef EXIBE_PISCA_FIM_EN
      // One dark entry cycle, then TEMPO_ACESO lit cycles, then FIM.
      PISCA: begin
        if (timer_q == FIM_PISCA) begin
          leds_d   = '0;
          timer_d  = '0;
          state_d  = FIM;
          pronto_d = 1'b1;
        end else begin
          leds_d  = '1;
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      FIM:     state_d = INICIAL;
      default: state_d = INICIAL;
    endcase

    // Abort overrides any in-flight transition, including the pronto pulse.
    if (parar && (state_q != INICIAL)) begin
      state_d  = INICIAL;
      leds_d   = '0;
      timer_d  = '0;
      pronto_d = 1'b0;
    end
  end

  always_comb begin
    ocupado = (state_q == CARREGA) || (state_q == ACESO) || (state_q == APAGADO)
`ifdef EXIBE_PISCA_FIM_EN
              || (state_q == PISCA)
`endif
              ;
  end

  assign db_estado    = state_q;
  assign leds         = leds_q;
  assign mem_endereco = end_q;
  assign pronto       = pronto_q;

endmodule
